// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with a hardware clear sweep (IDLE/SWEEP FSM).
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read port.
module regfile_2r1w #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int ZERO_REG = 0
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] rdAddrA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic [DATA_W-1:0] readDataA,
  output logic [DATA_W-1:0] readDataB,
  input  logic              clear,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            state;
  state_t            nextState;
  logic [ADDR_W-1:0] clrPtr;
  logic [ADDR_W-1:0] nextPtr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wrZeroHit;
  logic              rdZeroA;
  logic              rdZeroB;

  assign busy      = reset || (state == SWEEP);
  assign wrZeroHit = (ZERO_REG != 0) && (wrAddr == '0);
  assign rdZeroA   = (ZERO_REG != 0) && (rdAddrA == '0);
  assign rdZeroB   = (ZERO_REG != 0) && (rdAddrB == '0);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state  <= SWEEP;
      clrPtr <= '0;
    end else begin
      state  <= nextState;
      clrPtr <= nextPtr;
    end
  end

  always_comb begin
    nextState = state;
    nextPtr   = clrPtr;
    case (state)
      IDLE: begin
        if (clear) begin
          nextState = SWEEP;
          nextPtr   = '0;
        end
      end
      SWEEP: begin
        // Pointer wraps to 0 naturally as the last entry is cleared.
        nextPtr = clrPtr + 1'b1;
        if (clrPtr == {ADDR_W{1'b1}}) nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
        nextPtr   = '0;
      end
    endcase
  end

  // The sweep owns the write port; user writes only land while idle.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      if (state == SWEEP) mem[clrPtr] <= '0;
      else if (write && !wrZeroHit) mem[wrAddr] <= writeData;
    end
  end

  always_comb begin
    readDataA = mem[rdAddrA];
    readDataB = mem[rdAddrB];
`ifdef REGFILE_BYPASS_EN
    if (write && !busy && (rdAddrA == wrAddr)) readDataA = writeData;
    if (write && !busy && (rdAddrB == wrAddr)) readDataB = writeData;
`endif
    if (busy || rdZeroA) readDataA = '0;
    if (busy || rdZeroB) readDataB = '0;
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: reset/clear sweeps, directed table, random traffic vs array model.
// Expectations for same-cycle reads follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_2r1w;

  localparam int DEPTH = 256;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  wrAddr = '0;
  logic [15:0] writeData = '0;
  logic [7:0]  rdAddrA = '0;
  logic [7:0]  rdAddrB = '0;
  logic [15:0] readDataA;
  logic [15:0] readDataB;
  logic        clear = 1'b0;
  logic        busy;

  logic        zWrite = 1'b0;
  logic [3:0]  zWrAddr = '0;
  logic [15:0] zWriteData = '0;
  logic [3:0]  zRdA = '0;
  logic [3:0]  zRdB = '0;
  logic [15:0] zA;
  logic [15:0] zB;
  logic        zClear = 1'b0;
  logic        zBusy;

  int errors = 0;
  int checks = 0;
  int busyCount = 0;
  int sweepLeft = 0;
  logic [15:0] model [DEPTH];

  typedef struct {
    bit          wr;
    logic [7:0]  wa;
    logic [15:0] wd;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] expA;
    logic [15:0] expB;
    bit          expBusy;
  } vec_t;

  vec_t vecs [5];

  always #5 CLK = ~CLK;

  regfile_2r1w #(.DATA_W(16), .ADDR_W(8), .ZERO_REG(0)) dut (
    .CLK(CLK), .reset(reset), .write(write), .wrAddr(wrAddr), .writeData(writeData),
    .rdAddrA(rdAddrA), .rdAddrB(rdAddrB), .readDataA(readDataA), .readDataB(readDataB),
    .clear(clear), .busy(busy)
  );

  regfile_2r1w #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dutZ (
    .CLK(CLK), .reset(reset), .write(zWrite), .wrAddr(zWrAddr), .writeData(zWriteData),
    .rdAddrA(zRdA), .rdAddrB(zRdB), .readDataA(zA), .readDataB(zB),
    .clear(zClear), .busy(zBusy)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] expRead(input logic [7:0] addr, input bit wr,
                                          input logic [7:0] wa, input logic [15:0] wd,
                                          input bit busyM);
    if (busyM) return 16'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr && addr == wa) return wd;
`endif
    return model[addr];
  endfunction

  // One clock cycle: drive, check combinational outputs against the model, then advance the model.
  task automatic applyStimulus(input bit rst, input bit wr, input bit clr,
                               input logic [7:0] wa, input logic [15:0] wd,
                               input logic [7:0] ra, input logic [7:0] rb,
                               input bit chk, output bit busySeen);
    bit busyM;
    reset = rst; write = wr; clear = clr;
    wrAddr = wa; writeData = wd; rdAddrA = ra; rdAddrB = rb;
    #2;
    busyM = rst || (sweepLeft > 0);
    busySeen = busy;
    if (busy) busyCount++;
    if (chk) begin
      checkOutput("busy", 32'(busy), 32'(busyM));
      checkOutput("readDataA", 32'(readDataA), 32'(expRead(ra, wr, wa, wd, busyM)));
      checkOutput("readDataB", 32'(readDataB), 32'(expRead(rb, wr, wa, wd, busyM)));
    end
    @(posedge CLK);
    if (rst) begin
      sweepLeft = DEPTH;
      foreach (model[i]) model[i] = '0;
    end else if (sweepLeft > 0) begin
      sweepLeft--;
    end else begin
      if (wr) model[wa] = wd;
      if (clr) begin
        sweepLeft = DEPTH;
        foreach (model[i]) model[i] = '0;
      end
    end
    #1;
  endtask

  task automatic waitIdle();
    bit b;
    b = 1'b1;
    for (int k = 0; k < 600 && b; k++) applyStimulus(0, 0, 0, 8'h0, 16'h0, 8'(k), 8'(255 - k), 1, b);
    if (b) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitIdle: busy still %0b expected 0 after 600 cycles", b);
    end
  endtask

  initial begin
    bit b;
    logic [7:0] wa;
    vecs[0] = '{1'b1, 8'h10, 16'hBEEF, 8'h00, 8'hFF, 16'h0000, 16'h0000, 1'b0};
    vecs[1] = '{1'b1, 8'hFF, 16'h1234, 8'h10, 8'h01, 16'hBEEF, 16'h0000, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 16'h0000, 8'h10, 8'hFF, 16'hBEEF, 16'h1234, 1'b0};
    vecs[3] = '{1'b1, 8'h10, 16'h5A5A, 8'hFF, 8'hFF, 16'h1234, 16'h1234, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 16'h0000, 8'h10, 8'h10, 16'h5A5A, 16'h5A5A, 1'b0};
    foreach (model[i]) model[i] = '0;

    $display("[TB] reset sweep");
    applyStimulus(1, 0, 0, 8'h0, 16'h0, 8'h0, 8'hFF, 1, b);
    busyCount = 0;
    waitIdle();
    checkOutput("resetSweepLen", 32'(busyCount), 32'd256);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 8'h0, 16'h0, 8'(i), 8'(255 - i), 1, b);

    $display("[TB] zero-register instance");
    zWrite = 1'b1; zWrAddr = 4'h0; zWriteData = 16'h5555; zRdA = 4'h0; zRdB = 4'h0;
    #2;
    checkOutput("zReadA0SameCycle", 32'(zA), 32'h0);
    @(posedge CLK); #1;
    zWrite = 1'b0;
    #2;
    checkOutput("zReadA0", 32'(zA), 32'h0);
    checkOutput("zReadB0", 32'(zB), 32'h0);
    checkOutput("zBusy", 32'(zBusy), 32'h0);
    @(posedge CLK); #1;
    zWrite = 1'b1; zWrAddr = 4'h2; zWriteData = 16'h7777; zRdA = 4'h2; zRdB = 4'h3;
    #2;
`ifdef REGFILE_BYPASS_EN
    checkOutput("zBypassNew", 32'(zA), 32'h7777);
`else
    checkOutput("zNoBypassOld", 32'(zA), 32'h0);
`endif
    checkOutput("zReadB3", 32'(zB), 32'h0);
    @(posedge CLK); #1;
    zWriteData = 16'h1111;
    #2;
`ifdef REGFILE_BYPASS_EN
    checkOutput("zBypassOverwrite", 32'(zA), 32'h1111);
`else
    checkOutput("zOldValue", 32'(zA), 32'h7777);
`endif
    @(posedge CLK); #1;
    zWrite = 1'b0;
    #2;
    checkOutput("zReadBack", 32'(zA), 32'h1111);
    @(posedge CLK); #1;

    $display("[TB] directed table");
    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].wr, 0, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb, 0, b);
      checkOutput($sformatf("vec%0d_A", i), 32'(readDataA), 32'(vecs[i].expA));
      checkOutput($sformatf("vec%0d_B", i), 32'(readDataB), 32'(vecs[i].expB));
      checkOutput($sformatf("vec%0d_busy", i), 32'(b), 32'(vecs[i].expBusy));
    end

    $display("[TB] write plus clear, write and clear during sweep");
    busyCount = 0;
    applyStimulus(0, 1, 1, 8'h05, 16'hAAAA, 8'h05, 8'h10, 1, b);
    applyStimulus(0, 1, 0, 8'h06, 16'h1111, 8'h06, 8'h05, 1, b);
    for (int k = 0; k < 48; k++) applyStimulus(0, 0, 0, 8'h0, 16'h0, 8'h05, 8'h06, 1, b);
    applyStimulus(0, 0, 1, 8'h0, 16'h0, 8'h05, 8'h06, 1, b);
    waitIdle();
    checkOutput("clearSweepLen", 32'(busyCount), 32'd256);
    applyStimulus(0, 0, 0, 8'h0, 16'h0, 8'h05, 8'h06, 1, b);
    checkOutput("cleared05", 32'(readDataA), 32'h0);
    checkOutput("ignored06", 32'(readDataB), 32'h0);

    $display("[TB] reset mid-sweep");
    applyStimulus(0, 1, 0, 8'h33, 16'hDEAD, 8'h33, 8'h00, 1, b);
    applyStimulus(0, 0, 1, 8'h0, 16'h0, 8'h33, 8'h00, 1, b);
    for (int k = 0; k < 100; k++) applyStimulus(0, 0, 0, 8'h0, 16'h0, 8'h33, 8'(k), 1, b);
    applyStimulus(1, 1, 1, 8'h40, 16'hCAFE, 8'h40, 8'h33, 1, b);
    busyCount = 0;
    waitIdle();
    checkOutput("restartSweepLen", 32'(busyCount), 32'd256);
    applyStimulus(0, 0, 0, 8'h0, 16'h0, 8'h40, 8'h33, 1, b);

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      wa = 8'($urandom);
      applyStimulus(($urandom_range(0, 999) == 0), 1'($urandom), ($urandom_range(0, 399) == 0),
                    wa, 16'($urandom),
                    ($urandom_range(0, 2) == 0) ? wa : 8'($urandom),
                    ($urandom_range(0, 2) == 0) ? wa : 8'($urandom), 1, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning entry width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning address width; depth DEPTH = 2**ADDR_W entries.
REQ-003 The block SHALL have parameter ZERO_REG, default 0, meaning when 1 entry 0 is hardwired to zero.
REQ-004 The block SHALL have port CLK  input  1  the single clock; all state updates on rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port write  input  1  write enable.
REQ-007 The block SHALL have port wrAddr  input  ADDR_W  write address.
REQ-008 The block SHALL have port writeData  input  DATA_W  write data.
REQ-009 The block SHALL have ports rdAddrA / rdAddrB  input  ADDR_W  read addresses, ports A and B.
REQ-010 The block SHALL have ports readDataA / readDataB  output  DATA_W  read data, ports A and B.
REQ-011 The block SHALL have port clear  input  1  one-cycle request to zero the whole array.
REQ-012 The block SHALL have port busy  output  1  high while a clear sweep runs.

Function
REQ-013 Reads SHALL be combinational: readDataX = array[rdAddrX], zero latency, both ports independent.
REQ-014 When write=1 and busy=0, array[wrAddr] SHALL take writeData at the rising edge.
REQ-015 Clear FSM SHALL have states IDLE and SWEEP, with a registered ADDR_W-bit pointer clrPtr.
REQ-016 In IDLE with clear=1, the FSM SHALL go to SWEEP with clrPtr=0 at the next edge; busy=1 from that edge.
REQ-017 In SWEEP, each cycle SHALL write 0 to array[clrPtr] and increment clrPtr.
REQ-018 When clrPtr=DEPTH-1, SWEEP SHALL clear that entry and return to IDLE; clrPtr wraps to 0; total sweep is exactly DEPTH cycles.
REQ-019 While busy=1, readDataA/B SHALL read 0 and write SHALL be ignored (no array update, no buffering).
REQ-020 When clear=1 and write=1 arrive together in IDLE, the write SHALL complete, then the sweep zeroes it.
REQ-021 clear asserted during SWEEP SHALL be ignored; the sweep does not restart.
REQ-022 If ZERO_REG=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return 0 on both ports.
REQ-023 Every entry including DEPTH-1 SHALL be cleared by a sweep.

Reset
REQ-024 While reset=1, the FSM SHALL be forced to SWEEP with clrPtr=0 and busy=1, and no array writes occur.
REQ-025 After reset falls, the sweep SHALL clear entries 0..DEPTH-1 over the next DEPTH cycles, then busy=0.
REQ-026 reset asserted mid-sweep SHALL restart the sweep from entry 0.
REQ-027 reset SHALL take priority over clear and write.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN, when defined: if write=1, busy=0 and rdAddrX=wrAddr, readDataX SHALL equal writeData in the same cycle.
REQ-029 Bypass SHALL honour ZERO_REG (address 0 still reads 0).
REQ-030 Without REGFILE_BYPASS_EN, readDataX SHALL show the pre-write stored value until the edge.

Verification
REQ-031 Reset 1 cycle, release -> busy=1 for exactly 256 cycles (defaults), then 0; all 256 entries read 0, including 0xFF.
REQ-032 Write 0xBEEF @0x10, 0x1234 @0xFF; rdAddrA=0x10, rdAddrB=0xFF -> readDataA=0xBEEF, readDataB=0x1234 next cycle.
REQ-033 Write 0xAAAA @0x05 plus clear the same cycle -> busy rises; write during sweep ignored; after 256 cycles 0x05 reads 0.
REQ-034 Reset asserted at sweep cycle 100 -> busy stays high; 256 more cycles after release; array all zero.
REQ-035 ZERO_REG=1: write 0x5555 @0 -> readDataA @0 = 0; with REGFILE_BYPASS_EN, write 0x7777 @0x20 while rdAddrA=0x20 -> 0x7777 same cycle; without the macro -> old value.
